// File: rtl/bidir_bus_ctrl_pkg.sv
// Shared constants for the bidirectional bus controller: FSM encoding,
// owner encoding (matches the dir pin) and counter width.
package bidir_bus_pkg;

  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_TURN    = 2'd1;
  localparam state_t ST_DRIVE_A = 2'd2;
  localparam state_t ST_DRIVE_B = 2'd3;

  localparam logic OWN_A = 1'b1;
  localparam logic OWN_B = 1'b0;

  function automatic state_t drive_state(input logic owner);
    return (owner == OWN_A) ? ST_DRIVE_A : ST_DRIVE_B;
  endfunction

endpackage

// File: rtl/bidir_bus_ctrl_if.sv
// Request/grant/enable bundle between the two requesters and the controller.
interface bidir_bus_ctrl_if;

  logic req_a;
  logic req_b;
  logic gnt_a;
  logic gnt_b;
  logic oe_a;
  logic oe_b;
  logic dir;
  logic busy;

  modport master (
    output req_a, req_b,
    input  gnt_a, gnt_b, oe_a, oe_b, dir, busy
  );

  modport slave (
    input  req_a, req_b,
    output gnt_a, gnt_b, oe_a, oe_b, dir, busy
  );

endinterface

// File: rtl/bidir_bus_ctrl_turn_timer.sv
// Loadable down-counter timing the dead gap; done is high while the count
// sits at 1, i.e. during the last dead cycle.
module bus_turn_timer
  import bidir_bus_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  cnt_t load_val,
  output logic done
);

  cnt_t count_q;
  cnt_t count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == cnt_t'(1));

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Round-robin owner sequencer for a shared bidirectional line pair with a
// programmable turnaround gap and a bounded tenure per owner.
module bidir_bus_ctrl
  import bidir_bus_pkg::*;
#(
  parameter int TURN_CYC = 2,
  parameter int MAX_HOLD = 16
) (
  input logic             clk,
  input logic             rst_n,
  bidir_bus_ctrl_if.slave bus
);

  localparam cnt_t TURN_LOAD = cnt_t'(TURN_CYC);
  localparam cnt_t HOLD_MAX  = cnt_t'(MAX_HOLD);

  state_t state_q, state_d;
  logic   target_q, target_d;
  logic   last_owner_q, last_owner_d;
  logic   dir_q, dir_d;
  cnt_t   hold_q, hold_d;
  logic   gnt_a_q, gnt_b_q, busy_q;

  logic turn_load;
  logic turn_done;
  logic idle_tgt;
  logic drv_owner;
  logic own_req, oth_req;
  logic tgt_req, alt_req;

  // With both sides asking, the side that did not own the line last wins.
  assign idle_tgt  = (bus.req_a && bus.req_b) ? ~last_owner_q : bus.req_a;
  assign drv_owner = (state_q == ST_DRIVE_A) ? OWN_A : OWN_B;
  assign own_req   = drv_owner ? bus.req_a : bus.req_b;
  assign oth_req   = drv_owner ? bus.req_b : bus.req_a;
  assign tgt_req   = target_q ? bus.req_a : bus.req_b;
  assign alt_req   = target_q ? bus.req_b : bus.req_a;

  bus_turn_timer u_turn_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (turn_load),
    .load_val (TURN_LOAD),
    .done     (turn_done)
  );

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    last_owner_d = last_owner_q;
    dir_d        = dir_q;
    hold_d       = hold_q;
    turn_load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_a || bus.req_b) begin
          target_d = idle_tgt;
          dir_d    = idle_tgt;
          if (idle_tgt == last_owner_q) begin
            state_d = drive_state(idle_tgt);
            hold_d  = cnt_t'(1);
          end else begin
            state_d   = ST_TURN;
            turn_load = 1'b1;
          end
        end
      end

      ST_TURN: begin
        // A target that gave up during the gap never sees a grant.
        if (turn_done) begin
          if (tgt_req) begin
            state_d = drive_state(target_q);
            hold_d  = cnt_t'(1);
          end else if (alt_req) begin
            state_d  = drive_state(~target_q);
            target_d = ~target_q;
            dir_d    = ~target_q;
            hold_d   = cnt_t'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DRIVE_A, ST_DRIVE_B: begin
        if (!own_req || (hold_q == HOLD_MAX && oth_req)) begin
          last_owner_d = drv_owner;
          hold_d       = '0;
          if (oth_req) begin
            state_d   = ST_TURN;
            target_d  = ~drv_owner;
            dir_d     = ~drv_owner;
            turn_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      target_q     <= OWN_B;
      last_owner_q <= OWN_B;
      dir_q        <= 1'b0;
      hold_q       <= '0;
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      last_owner_q <= last_owner_d;
      dir_q        <= dir_d;
      hold_q       <= hold_d;
      gnt_a_q      <= (state_d == ST_DRIVE_A);
      gnt_b_q      <= (state_d == ST_DRIVE_B);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  // Pad enables coincide with grants; dir is registered on the same edge.
  assign bus.gnt_a = gnt_a_q;
  assign bus.gnt_b = gnt_b_q;
  assign bus.oe_a  = gnt_a_q;
  assign bus.oe_b  = gnt_b_q;
  assign bus.dir   = dir_q;
  assign bus.busy  = busy_q;

endmodule
